branch_wait_multi: RTL and testbench
====================================

Name: branch_wait_multi

Overview:
- Parametrised per-wavefront pending-branch tracker for the compute unit.
- Counts outstanding branches per wavefront rather than holding one bit, so a wavefront may have up to MAX_OUTSTANDING unresolved branches.
- Accepts NUM_ISSUE branch-issue channels and NUM_RESOLVE SALU outcome channels per cycle, plus a per-wavefront flush.
- Runs a per-wavefront watchdog and reports sticky protocol errors. Issue uses its outputs to gate wavefront selection.

Parameters:
- NUM_WF, 40: wavefronts tracked.
- WFID_W, 6: wavefront id width.
- NUM_ISSUE, 2: branch-issue channels.
- NUM_RESOLVE, 2: branch-resolve channels.
- MAX_OUTSTANDING, 3: per-wavefront counter ceiling, >=1. CNT_W = clog2(MAX_OUTSTANDING+1), derived.
- TIMEOUT, 1024: watchdog cycles. 0 disables the watchdog. AGE_W = clog2(TIMEOUT+1), derived.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- alu_valid  in  NUM_ISSUE  per-channel issue valid.
- alu_branch  in  NUM_ISSUE  per-channel "issued instruction is a branch".
- alu_wfid  in  NUM_ISSUE*WFID_W  per-channel wavefront id, channel k at [k*WFID_W +: WFID_W].
- f_salu_branch_en  in  NUM_RESOLVE  per-channel branch outcome valid.
- f_salu_branch_wfid  in  NUM_RESOLVE*WFID_W  per-channel resolved wavefront id.
- flush_wf  in  NUM_WF  bitmask of wavefronts being killed or halted.
- pending_branches_arry  out  NUM_WF  count[w] != 0.
- branch_full_arry  out  NUM_WF  count[w] == MAX_OUTSTANDING.
- timeout_arry  out  NUM_WF  watchdog expired for wavefront w.
- err_overflow  out  1  sticky: increment requested at ceiling.
- err_underflow  out  1  sticky: resolve requested at zero.
- err_bad_wfid  out  1  sticky: any valid id >= NUM_WF.

Behaviour:
- State per wavefront: count[w] (CNT_W bits) and age[w] (AGE_W bits). All outputs are derived from registered state, so there are no combinational input-to-output paths.
- Reset: when rst==0 at a clock edge, all counts, ages and error flags go to 0, so every output is 0 the next cycle. Reset mid-operation discards all in-flight state, with no partial effects.
- Events for wavefront w:
  - inc[w] = number of issue channels with alu_valid & alu_branch & alu_wfid==w (0..NUM_ISSUE).
  - dec[w] = number of resolve channels with f_salu_branch_en & f_salu_branch_wfid==w.
- Next count, in priority order:
  - flush_wf[w]=1: count is set to 0 and same-cycle inc/dec are ignored. No error is flagged for ignored events.
  - Otherwise, sum = count + inc - dec in signed arithmetic wide enough for the range.
    - If sum < 0: count is set to 0 and err_underflow is set.
    - If sum > MAX_OUTSTANDING: count is set to MAX_OUTSTANDING and err_overflow is set.
    - Otherwise count is set to sum.
- Simultaneous issue and resolve on the same wavefront net out: at count=1, inc=1, dec=1, count stays 1 with no error.
- Latency: an event at edge N is visible on pending_branches_arry and branch_full_arry after edge N (one cycle). This matches the single-bit tracker's timing.
- Bad ids: an id >= NUM_WF on any valid channel is ignored for counting and sets err_bad_wfid. Ids on channels whose valid is low are never checked.
- Watchdog, active only when TIMEOUT != 0:
  - age[w] clears to 0 on any of: flush, dec[w] > 0, or next count == 0.
  - Otherwise, while count[w] != 0, age increments, saturating at TIMEOUT.
  - timeout_arry[w] = (age[w] == TIMEOUT).
  - Issue-only cycles do not clear age; the watchdog measures time since the last resolve.
  - With TIMEOUT=0, age is held at 0 and timeout_arry is constant 0.
- Sticky errors clear only on reset.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles with random inputs, then release -> all outputs 0; the first cycle after release still reads 0.
- Single issue/resolve: ch0 issues wf 5 at cycle 1 -> pending[5]=1 at cycle 2. Resolve wf 5 at cycle 4 -> pending[5]=0 at cycle 5, errors 0.
- Dual issue to the ceiling: both channels issue wf 39 in one cycle, then one more issue next cycle (MAX=3) -> count 2 then 3 and branch_full_arry[39]=1. A fourth issue -> count stays 3 and err_overflow=1.
- Net and flush: wf 7 at count=1 with one issue plus one resolve -> count 1, no error. Then flush_wf[7] together with two issues -> count 0, pending[7]=0, no error.
- Underflow and bad id: resolve wf 3 at count 0 -> err_underflow=1, count 0. Issue with wfid=45 -> err_bad_wfid=1, no pending bit changes.
- Watchdog (TIMEOUT=4): issue wf 10, no resolve -> timeout_arry[10]=1 exactly 4 cycles after the count first reads 1. An additional issue does not clear it; a resolve clears it the next cycle.

Source files
------------

// File: rtl/branch_wait_multi.sv
// -----------------------------------------------------------------------------
// branch_wait_multi
//
// Per-wavefront pending-branch tracker. Each wavefront keeps a small saturating
// counter of unresolved branches (up to MAX_OUTSTANDING) plus a watchdog age
// that measures cycles since the last resolve while branches are outstanding.
// Issue uses pending/full to gate wavefront selection.
//
// Ports
//   clk                    clock
//   rst                    synchronous reset, active low
//   alu_valid              per issue channel: valid
//   alu_branch             per issue channel: issued instruction is a branch
//   alu_wfid               per issue channel: wavefront id, channel k at [k*WFID_W +: WFID_W]
//   f_salu_branch_en       per resolve channel: branch outcome valid
//   f_salu_branch_wfid     per resolve channel: resolved wavefront id
//   flush_wf               per wavefront: kill/halt, clears the counter
//   pending_branches_arry  per wavefront: count != 0
//   branch_full_arry       per wavefront: count == MAX_OUTSTANDING
//   timeout_arry           per wavefront: watchdog expired
//   err_overflow           sticky: increment requested beyond the ceiling
//   err_underflow          sticky: resolve requested below zero
//   err_bad_wfid           sticky: valid channel carried an id >= NUM_WF
//
// All outputs come straight from registers; there is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module branch_wait_multi #(
    parameter int NUM_WF          = 40,
    parameter int WFID_W          = 6,
    parameter int NUM_ISSUE       = 2,
    parameter int NUM_RESOLVE     = 2,
    parameter int MAX_OUTSTANDING = 3,
    parameter int TIMEOUT         = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_ISSUE-1:0]          alu_valid,
    input  logic [NUM_ISSUE-1:0]          alu_branch,
    input  logic [NUM_ISSUE*WFID_W-1:0]   alu_wfid,
    input  logic [NUM_RESOLVE-1:0]        f_salu_branch_en,
    input  logic [NUM_RESOLVE*WFID_W-1:0] f_salu_branch_wfid,
    input  logic [NUM_WF-1:0]             flush_wf,
    output logic [NUM_WF-1:0]             pending_branches_arry,
    output logic [NUM_WF-1:0]             branch_full_arry,
    output logic [NUM_WF-1:0]             timeout_arry,
    output logic                          err_overflow,
    output logic                          err_underflow,
    output logic                          err_bad_wfid
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    // A disabled watchdog still gets a 1-bit age so the vectors stay legal;
    // it is held at zero below.
    localparam int AGE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int INC_W = $clog2(NUM_ISSUE + 1);
    localparam int DEC_W = $clog2(NUM_RESOLVE + 1);
    // Signed range is -NUM_RESOLVE .. MAX_OUTSTANDING+NUM_ISSUE; one extra
    // bit on top of the magnitude carries the sign.
    localparam int SUM_W = $clog2(MAX_OUTSTANDING + NUM_ISSUE + NUM_RESOLVE + 1) + 1;

    localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [AGE_W-1:0]        AGE_MAX = AGE_W'(TIMEOUT);
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(MAX_OUTSTANDING);

    // ------------------------------------------------------------------
    // Channel decode: split ids, qualify valids, flag out-of-range ids.
    // ------------------------------------------------------------------
    logic [NUM_ISSUE-1:0][WFID_W-1:0]   issue_id;
    logic [NUM_RESOLVE-1:0][WFID_W-1:0] resolve_id;
    logic [NUM_ISSUE-1:0]               issue_bad;
    logic [NUM_RESOLVE-1:0]             resolve_bad;
    logic [NUM_ISSUE-1:0]               issue_use;
    logic [NUM_RESOLVE-1:0]             resolve_use;

    assign issue_id   = alu_wfid;
    assign resolve_id = f_salu_branch_wfid;

    always_comb begin
        for (int k = 0; k < NUM_ISSUE; k++) begin
            issue_bad[k] = alu_valid[k] && (int'(issue_id[k]) >= NUM_WF);
            issue_use[k] = alu_valid[k] && alu_branch[k] && !issue_bad[k];
        end
        for (int k = 0; k < NUM_RESOLVE; k++) begin
            resolve_bad[k] = f_salu_branch_en[k] && (int'(resolve_id[k]) >= NUM_WF);
            resolve_use[k] = f_salu_branch_en[k] && !resolve_bad[k];
        end
    end

    // ------------------------------------------------------------------
    // Per-wavefront counter and watchdog.
    // ------------------------------------------------------------------
    logic [NUM_WF-1:0] ovf_hit;
    logic [NUM_WF-1:0] unf_hit;

    for (genvar w = 0; w < NUM_WF; w++) begin : g_wf
        logic [CNT_W-1:0]        cnt_q, cnt_d;
        logic [AGE_W-1:0]        age_q, age_d;
        logic [INC_W-1:0]        inc_v;
        logic [DEC_W-1:0]        dec_v;
        logic signed [SUM_W-1:0] sum_v;

        always_comb begin
            inc_v = '0;
            for (int k = 0; k < NUM_ISSUE; k++) begin
                if (issue_use[k] && (issue_id[k] == WFID_W'(w))) begin
                    inc_v = inc_v + INC_W'(1);
                end
            end
            dec_v = '0;
            for (int k = 0; k < NUM_RESOLVE; k++) begin
                if (resolve_use[k] && (resolve_id[k] == WFID_W'(w))) begin
                    dec_v = dec_v + DEC_W'(1);
                end
            end
        end

        always_comb begin
            sum_v      = SUM_W'(cnt_q) + SUM_W'(inc_v) - SUM_W'(dec_v);
            ovf_hit[w] = 1'b0;
            unf_hit[w] = 1'b0;
            // Flush wins outright; events swallowed by a flush are not errors.
            if (flush_wf[w]) begin
                cnt_d = '0;
            end else if (sum_v[SUM_W-1]) begin
                cnt_d      = '0;
                unf_hit[w] = 1'b1;
            end else if (sum_v > SUM_MAX) begin
                cnt_d      = CNT_MAX;
                ovf_hit[w] = 1'b1;
            end else begin
                cnt_d = CNT_W'(sum_v);
            end
        end

        // Age counts time since the last resolve; an issue alone never resets
        // it, so a wavefront that keeps issuing cannot hide a stuck resolve.
        always_comb begin
            if ((TIMEOUT == 0) || flush_wf[w] || (dec_v != '0) || (cnt_d == '0)) begin
                age_d = '0;
            end else if ((cnt_q != '0) && (age_q != AGE_MAX)) begin
                age_d = age_q + AGE_W'(1);
            end else begin
                age_d = age_q;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                cnt_q <= '0;
                age_q <= '0;
            end else begin
                cnt_q <= cnt_d;
                age_q <= age_d;
            end
        end

        assign pending_branches_arry[w] = (cnt_q != '0);
        assign branch_full_arry[w]      = (cnt_q == CNT_MAX);
        assign timeout_arry[w]          = (TIMEOUT != 0) && (age_q == AGE_MAX);
    end

    // ------------------------------------------------------------------
    // Sticky error flags.
    // ------------------------------------------------------------------
    logic err_ovf_q, err_ovf_d;
    logic err_unf_q, err_unf_d;
    logic err_bad_q, err_bad_d;

    always_comb begin
        err_ovf_d = err_ovf_q | (|ovf_hit);
        err_unf_d = err_unf_q | (|unf_hit);
        err_bad_d = err_bad_q | (|issue_bad) | (|resolve_bad);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
            err_bad_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
            err_bad_q <= err_bad_d;
        end
    end

    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_unf_q;
    assign err_bad_wfid  = err_bad_q;

endmodule

// File: tb/tb_branch_wait_multi.sv
// -----------------------------------------------------------------------------
// Bench for branch_wait_multi (TIMEOUT reduced to 4 so the watchdog is
// reachable). A behavioural model tracks per-wavefront counts and ages with
// plain integers; a negedge process compares every output against it each
// cycle, and the directed sequence adds hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_branch_wait_multi;

    localparam int NWF  = 40;
    localparam int IDW  = 6;
    localparam int NIS  = 2;
    localparam int NRS  = 2;
    localparam int MAXO = 3;
    localparam int TO   = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NIS-1:0]      alu_valid;
    logic [NIS-1:0]      alu_branch;
    logic [NIS*IDW-1:0]  alu_wfid;
    logic [NRS-1:0]      br_en;
    logic [NRS*IDW-1:0]  br_wfid;
    logic [NWF-1:0]      flush_wf;
    logic [NWF-1:0]      pend;
    logic [NWF-1:0]      full;
    logic [NWF-1:0]      tmo;
    logic                e_ovf, e_unf, e_bad;

    always #5 clk = ~clk;

    branch_wait_multi #(
        .NUM_WF(NWF), .WFID_W(IDW), .NUM_ISSUE(NIS), .NUM_RESOLVE(NRS),
        .MAX_OUTSTANDING(MAXO), .TIMEOUT(TO)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .alu_valid             (alu_valid),
        .alu_branch            (alu_branch),
        .alu_wfid              (alu_wfid),
        .f_salu_branch_en      (br_en),
        .f_salu_branch_wfid    (br_wfid),
        .flush_wf              (flush_wf),
        .pending_branches_arry (pend),
        .branch_full_arry      (full),
        .timeout_arry          (tmo),
        .err_overflow          (e_ovf),
        .err_underflow         (e_unf),
        .err_bad_wfid          (e_bad)
    );

    // ---------------- model ----------------
    int m_cnt [NWF];
    int m_age [NWF];
    bit m_ovf, m_unf, m_bad;

    int n_vec  = 0;
    int n_mis  = 0;
    bit chk_en = 1'b0;

    task automatic model_step();
        int inc [NWF];
        int dec [NWF];
        int id, s, nc;
        if (!rst) begin
            for (int w = 0; w < NWF; w++) begin
                m_cnt[w] = 0;
                m_age[w] = 0;
            end
            m_ovf = 0; m_unf = 0; m_bad = 0;
            return;
        end
        for (int w = 0; w < NWF; w++) begin
            inc[w] = 0;
            dec[w] = 0;
        end
        for (int k = 0; k < NIS; k++) begin
            if (alu_valid[k]) begin
                id = int'(alu_wfid[k*IDW +: IDW]);
                if (id >= NWF) m_bad = 1;
                else if (alu_branch[k]) inc[id]++;
            end
        end
        for (int k = 0; k < NRS; k++) begin
            if (br_en[k]) begin
                id = int'(br_wfid[k*IDW +: IDW]);
                if (id >= NWF) m_bad = 1;
                else dec[id]++;
            end
        end
        for (int w = 0; w < NWF; w++) begin
            if (flush_wf[w]) begin
                nc = 0;
            end else begin
                s = m_cnt[w] + inc[w] - dec[w];
                if (s < 0) begin
                    nc = 0; m_unf = 1;
                end else if (s > MAXO) begin
                    nc = MAXO; m_ovf = 1;
                end else begin
                    nc = s;
                end
            end
            if (flush_wf[w] || dec[w] > 0 || nc == 0) m_age[w] = 0;
            else if (m_cnt[w] != 0 && m_age[w] < TO) m_age[w] = m_age[w] + 1;
            m_cnt[w] = nc;
        end
    endtask

    function automatic logic [NWF-1:0] exp_pend();
        logic [NWF-1:0] v;
        for (int w = 0; w < NWF; w++) v[w] = (m_cnt[w] != 0);
        return v;
    endfunction

    function automatic logic [NWF-1:0] exp_full();
        logic [NWF-1:0] v;
        for (int w = 0; w < NWF; w++) v[w] = (m_cnt[w] == MAXO);
        return v;
    endfunction

    function automatic logic [NWF-1:0] exp_tmo();
        logic [NWF-1:0] v;
        for (int w = 0; w < NWF; w++) v[w] = (m_age[w] == TO);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_pending", 64'(pend), 64'(exp_pend()));
            chk("cyc_full",    64'(full), 64'(exp_full()));
            chk("cyc_timeout", 64'(tmo),  64'(exp_tmo()));
            chk("cyc_err_ovf", 64'(e_ovf), 64'(m_ovf));
            chk("cyc_err_unf", 64'(e_unf), 64'(m_unf));
            chk("cyc_err_bad", 64'(e_bad), 64'(m_bad));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        alu_valid  = '0;
        alu_branch = '0;
        alu_wfid   = '0;
        br_en      = '0;
        br_wfid    = '0;
        flush_wf   = '0;
    endtask

    task automatic issue(input int ch, input int id);
        alu_valid[ch]            = 1'b1;
        alu_branch[ch]           = 1'b1;
        alu_wfid[ch*IDW +: IDW]  = IDW'(id);
    endtask

    task automatic resolve(input int ch, input int id);
        br_en[ch]               = 1'b1;
        br_wfid[ch*IDW +: IDW]  = IDW'(id);
    endtask

    task automatic rand_inputs();
        alu_valid  = NIS'($urandom());
        alu_branch = NIS'($urandom());
        alu_wfid   = (NIS*IDW)'($urandom());
        br_en      = NRS'($urandom());
        br_wfid    = (NRS*IDW)'($urandom());
        flush_wf   = NWF'({$urandom(), $urandom()});
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_pend"}, 64'(pend), 64'd0);
        chk({name, "_full"}, 64'(full), 64'd0);
        chk({name, "_tmo"},  64'(tmo),  64'd0);
        chk({name, "_errs"}, 64'({e_ovf, e_unf, e_bad}), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int id;
        rst = 1'b0;
        idle();
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            tick();
        end
        chk_en = 1'b1;
        chk_all_zero("reset_hold");
        rst = 1'b1;
        idle();
        tick();
        chk_all_zero("first_after_release");

        // single issue / resolve on wf 5
        issue(0, 5);
        tick();
        idle();
        chk("issue5_pend", 64'(pend[5]), 64'd1);
        tick();
        tick();
        resolve(0, 5);
        tick();
        idle();
        chk("resolve5_pend", 64'(pend[5]), 64'd0);
        chk("resolve5_errs", 64'({e_ovf, e_unf, e_bad}), 64'd0);

        // dual issue to the ceiling on wf 39
        issue(0, 39);
        issue(1, 39);
        tick();
        idle();
        chk("wf39_model_cnt2", 64'(m_cnt[39]), 64'd2);
        chk("wf39_full_at2", 64'(full[39]), 64'd0);
        issue(0, 39);
        tick();
        idle();
        chk("wf39_full_at3", 64'(full[39]), 64'd1);
        chk("wf39_no_ovf_yet", 64'(e_ovf), 64'd0);
        issue(0, 39);
        tick();
        idle();
        chk("wf39_still_full", 64'(full[39]), 64'd1);
        chk("wf39_ovf", 64'(e_ovf), 64'd1);

        // net and flush on wf 7
        issue(0, 7);
        tick();
        idle();
        issue(0, 7);
        resolve(0, 7);
        tick();
        idle();
        chk("wf7_net_pend", 64'(pend[7]), 64'd1);
        chk("wf7_net_model", 64'(m_cnt[7]), 64'd1);
        chk("wf7_net_unf", 64'(e_unf), 64'd0);
        flush_wf[7] = 1'b1;
        issue(0, 7);
        issue(1, 7);
        tick();
        idle();
        chk("wf7_flush_pend", 64'(pend[7]), 64'd0);
        chk("wf7_flush_unf", 64'(e_unf), 64'd0);

        // underflow and bad id
        resolve(1, 3);
        tick();
        idle();
        chk("wf3_unf", 64'(e_unf), 64'd1);
        chk("wf3_pend", 64'(pend[3]), 64'd0);
        chk("no_bad_yet", 64'(e_bad), 64'd0);
        issue(1, 45);
        tick();
        idle();
        chk("bad_id_err", 64'(e_bad), 64'd1);
        chk("bad_id_pend", 64'(pend), 64'h80_0000_0000);

        // watchdog on wf 10
        issue(0, 10);
        tick();
        idle();
        chk("wd10_pend", 64'(pend[10]), 64'd1);
        chk("wd10_t0", 64'(tmo[10]), 64'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("wd10_early", 64'(tmo[10]), 64'd0);
        end
        tick();
        chk("wd10_expired", 64'(tmo[10]), 64'd1);
        issue(1, 10);
        tick();
        idle();
        chk("wd10_issue_keeps", 64'(tmo[10]), 64'd1);
        resolve(0, 10);
        tick();
        idle();
        chk("wd10_resolve_clears", 64'(tmo[10]), 64'd0);
        chk("wd10_pend_after", 64'(pend[10]), 64'd1);
        chk("wf39_timeout", 64'(tmo[39]), 64'd1);
        chk("wf39_model_age", 64'(m_age[39]), 64'(TO));

        // mid-operation reset
        rst = 1'b0;
        rand_inputs();
        tick();
        chk_all_zero("mid_reset");
        rst = 1'b1;
        idle();
        tick();
        chk_all_zero("mid_release");

        // mixed traffic, mostly in-range ids, checked by the per-cycle compare
        for (int c = 0; c < 400; c++) begin
            idle();
            for (int k = 0; k < NIS; k++) begin
                id = $urandom_range(0, 41);
                alu_valid[k]           = ($urandom_range(0, 2) != 0);
                alu_branch[k]          = (id >= NWF) ? 1'b1 : 1'($urandom_range(0, 1));
                alu_wfid[k*IDW +: IDW] = IDW'(id % 12);
                if (id >= NWF) alu_wfid[k*IDW +: IDW] = IDW'(id);
            end
            for (int k = 0; k < NRS; k++) begin
                id = $urandom_range(0, 41);
                br_en[k]              = ($urandom_range(0, 2) == 0);
                br_wfid[k*IDW +: IDW] = IDW'((id >= NWF) ? id : id % 12);
            end
            if ($urandom_range(0, 15) == 0) flush_wf = NWF'(1) << $urandom_range(0, 11);
            if (c == 200) begin
                rst = 1'b0;
            end else begin
                rst = 1'b1;
            end
            tick();
        end
        idle();
        tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_time_limit: got timeout expected finish");
        $fatal(1, "time limit");
    end

endmodule
